// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit feeding the HI/LO register file.
// Emits a one-cycle write-enable with HI/LO data; busy_o stalls the pipeline while iterating.
module muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] operandA_i,
  input  logic [WIDTH-1:0] operandB_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [1:0]       writeEnable_o,
  output logic [WIDTH-1:0] HI_data_o,
  output logic [WIDTH-1:0] LO_data_o
);

  localparam int unsigned CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // opa doubles as the dividend/quotient shift register during a divide
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] rem;
  logic             op_signed;
  logic             quo_neg;
  logic             rem_neg;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_direct;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_next;
  logic               a_neg;
  logic               b_neg;
  logic               is_signed_mul;

  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic [2*WIDTH-1:0] ax;
    logic [2*WIDTH-1:0] bx;
    ax = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ax * bx;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic sel);
    return sel ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Product of captured operands, plus a direct path for single-cycle multiply
  always_comb begin
    is_signed_mul = (op_i == OP_MULT);
    prod          = mul_full(opa, opb, op_signed);
    prod_direct   = mul_full(operandA_i, operandB_i, is_signed_mul);
  end

  // Operand signs for a signed divide; magnitudes are captured at acceptance
  always_comb begin
    a_neg = (op_i == OP_DIV) && operandA_i[WIDTH-1];
    b_neg = (op_i == OP_DIV) && operandB_i[WIDTH-1];
  end

  // One restoring-division step: shift in the next dividend bit, trial-subtract
  always_comb begin
    div_shift = {rem, opa[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (div_diff[WIDTH]) begin
      rem_next = div_shift[WIDTH-1:0];
      quo_next = {opa[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = div_diff[WIDTH-1:0];
      quo_next = {opa[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM with registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      busy_o        <= 1'b0;
      writeEnable_o <= 2'b00;
      HI_data_o     <= '0;
      LO_data_o     <= '0;
      opa           <= '0;
      opb           <= '0;
      rem           <= '0;
      op_signed     <= 1'b0;
      quo_neg       <= 1'b0;
      rem_neg       <= 1'b0;
    end else begin
      writeEnable_o <= 2'b00;
      HI_data_o     <= '0;
      LO_data_o     <= '0;
      if (flush_i) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              case (op_i)
                OP_MTHI: begin
                  writeEnable_o <= 2'b10;
                  HI_data_o     <= operandA_i;
                end
                OP_MTLO: begin
                  writeEnable_o <= 2'b01;
                  LO_data_o     <= operandA_i;
                end
                OP_MULT, OP_MULTU: begin
                  if (MUL_LATENCY == 1) begin
                    writeEnable_o <= 2'b11;
                    HI_data_o     <= prod_direct[2*WIDTH-1:WIDTH];
                    LO_data_o     <= prod_direct[WIDTH-1:0];
                  end else begin
                    opa       <= operandA_i;
                    opb       <= operandB_i;
                    op_signed <= is_signed_mul;
                    cnt       <= CNT_W'(MUL_LATENCY - 1);
                    state     <= ST_MUL;
                    busy_o    <= 1'b1;
                  end
                end
                OP_DIV, OP_DIVU: begin
                  if (operandB_i == '0) begin
                    writeEnable_o <= 2'b11;
                    HI_data_o     <= operandA_i;
                    LO_data_o     <= '1;
                  end else begin
                    opa     <= neg_if(operandA_i, a_neg);
                    opb     <= neg_if(operandB_i, b_neg);
                    rem     <= '0;
                    quo_neg <= a_neg ^ b_neg;
                    rem_neg <= a_neg;
                    cnt     <= CNT_W'(WIDTH);
                    state   <= ST_DIV;
                    busy_o  <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              writeEnable_o <= 2'b11;
              HI_data_o     <= prod[2*WIDTH-1:WIDTH];
              LO_data_o     <= prod[WIDTH-1:0];
              state         <= ST_IDLE;
              busy_o        <= 1'b0;
            end
          end
          ST_DIV: begin
            opa <= quo_next;
            rem <= rem_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              writeEnable_o <= 2'b11;
              HI_data_o     <= neg_if(rem_next, rem_neg);
              LO_data_o     <= neg_if(quo_next, quo_neg);
              state         <= ST_IDLE;
              busy_o        <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
